// File: rtl/yblock_cfg_seq_if.sv
// Row-slice configuration stream into yblock_cfg_seq: one bit per column per shift.
interface yblock_cfg_seq_if #(
  parameter int BLOCKWIDTH = 16
);
  logic                  load_valid;
  logic                  load_ready;
  logic [BLOCKWIDTH-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/yblock_cfg_seq.sv
// Configuration sequencer for one Morphle yblock: shifts row-slices into the column chains.
// Optional readback signature enabled by defining YBLOCK_CFG_READBACK_EN.
module yblock_cfg_seq #(
  parameter int BLOCKWIDTH  = 16,
  parameter int BLOCKHEIGHT = 16,
  parameter int CELLBITS    = 3,
  parameter int SETTLE      = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic                  abort,
  yblock_cfg_seq_if.slave       load,
  output logic                  cfg_o,
  output logic [BLOCKWIDTH-1:0] cbitin_o,
  input  logic [BLOCKWIDTH-1:0] cbitout_i,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [$clog2(BLOCKHEIGHT*CELLBITS+1)-1:0] shift_cnt,
  output logic [BLOCKWIDTH-1:0] rb_sig
);

  localparam int N  = BLOCKHEIGHT * CELLBITS;
  localparam int CW = $clog2(N + 1);
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] SETUP     = 3'd2;
  localparam logic [2:0] PULSE     = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]    state_reg;
  logic [TW-1:0] timer_reg;

  assign load.load_ready = (state_reg == WAIT_DATA);

`ifdef YBLOCK_CFG_READBACK_EN
  // Rotate-left-by-one then fold in the bits leaving the chains.
  logic [BLOCKWIDTH-1:0] rb_next;
  for (genvar gi = 0; gi < BLOCKWIDTH; gi++) begin : g_rb
    assign rb_next[gi] = rb_sig[(gi + BLOCKWIDTH - 1) % BLOCKWIDTH] ^ cbitout_i[gi];
  end
`else
  logic unused_cbitout;
  assign unused_cbitout = ^cbitout_i;
  assign rb_sig = '0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      cfg_o     <= 1'b0;
      cbitin_o  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      shift_cnt <= '0;
`ifdef YBLOCK_CFG_READBACK_EN
      rb_sig    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state_reg != IDLE)) begin
        // Abort wins over every state, including mid-pulse and HOLD.
        state_reg <= IDLE;
        cfg_o     <= 1'b0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !abort) begin
              state_reg <= WAIT_DATA;
              busy      <= 1'b1;
              aborted   <= 1'b0;
              shift_cnt <= '0;
`ifdef YBLOCK_CFG_READBACK_EN
              rb_sig    <= '0;
`endif
            end
          end
          WAIT_DATA: begin
            if (load.load_valid) begin
              cbitin_o  <= load.load_data;
              timer_reg <= TW'(SETTLE - 1);
              state_reg <= SETUP;
            end
          end
          SETUP: begin
            if (timer_reg == '0) begin
              state_reg <= PULSE;
              cfg_o     <= 1'b1;
              timer_reg <= TW'(SETTLE - 1);
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          PULSE: begin
            if (timer_reg == '0) begin
              state_reg <= HOLD;
              cfg_o     <= 1'b0;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          HOLD: begin
            shift_cnt <= shift_cnt + 1'b1;
`ifdef YBLOCK_CFG_READBACK_EN
            rb_sig    <= rb_next;
`endif
            if (shift_cnt == CW'(N - 1)) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= WAIT_DATA;
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            cfg_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
